// File: rtl/dot_prod_seq_pkg.sv
// Shared types and constants for the dot-product sequencer and its MAC.
package dot_prod_seq_pkg;

    localparam int ADDR_W = 4;           // operand RAM address width
    localparam int DATA_W = 8;           // signed operand width, matches the MAC input
    localparam int ACC_W  = 26;          // MAC accumulator width
    localparam int LEN_W  = ADDR_W + 1;  // wide enough to hold 2**ADDR_W

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CAPT,
        DONE
    } state_t;

    // Requested lengths beyond the RAM depth are limited to the RAM depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/dot_prod_seq_if.sv
// Control handshake between a requester and the dot-product sequencer.
interface dot_prod_seq_if;
    import dot_prod_seq_pkg::*;

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] result;

    // Requester side.
    modport master (
        output start, len,
        input  busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, len,
        output busy, done, result
    );

endinterface

// File: rtl/dot_prod_seq.sv
// Sequencer that streams len operand pairs from a synchronous RAM into a
// signed MAC, waits for the MAC pipeline to drain and captures the result.
module dot_prod_seq
    import dot_prod_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    dot_prod_seq_if.slave            ctl,
    output logic                     ram_rd_en_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    input  logic signed [DATA_W-1:0] ram_a_i,
    input  logic signed [DATA_W-1:0] ram_b_i,
    output logic signed [DATA_W-1:0] mac_in1_o,
    output logic signed [DATA_W-1:0] mac_in2_o,
    output logic                     mac_clr_o,
    input  logic signed [ACC_W-1:0]  mac_acc_i
);

    state_t                  state_q;
    logic [LEN_W-1:0]        len_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    drain_q;
    logic                    rd_en_q;
    logic                    clr_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [ACC_W-1:0] result_q;
    logic                    vld1_q;
    logic signed [DATA_W-1:0] in1_q;
    logic signed [DATA_W-1:0] in2_q;

    logic [LEN_W-1:0]        len_eff_d;
    logic                    last_addr_d;

    assign len_eff_d   = clamp_len(ctl.len);
    assign last_addr_d = ({1'b0, addr_q} == (len_q - LEN_W'(1)));

    // Control FSM: every output is a register updated alongside the state.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together at the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            drain_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctl.start) begin
                        if (len_eff_d == '0) begin
                            // Empty vector: report a zero result straight away.
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            len_q   <= len_eff_d;
                            addr_q  <= '0;
                            rd_en_q <= 1'b1;
                            clr_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The MAC is cleared only while the first address is out.
                    clr_q <= 1'b0;
                    if (last_addr_d) begin
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Two cycles: RAM read latency plus the operand register.
                    if (drain_q) begin
                        state_q <= CAPT;
                    end
                    drain_q <= 1'b1;
                end
                CAPT: begin
                    result_q <= mac_acc_i;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operand pipeline: forward RAM data one cycle after a read, zeros
    // otherwise so the MAC accumulator holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            in1_q  <= '0;
            in2_q  <= '0;
        end else begin
            vld1_q <= rd_en_q;
            in1_q  <= vld1_q ? ram_a_i : '0;
            in2_q  <= vld1_q ? ram_b_i : '0;
        end
    end

    assign ram_rd_en_o = rd_en_q;
    assign ram_addr_o  = addr_q;
    assign mac_clr_o   = clr_q;
    assign mac_in1_o   = in1_q;
    assign mac_in2_o   = in2_q;
    assign ctl.busy    = busy_q;
    assign ctl.done    = done_q;
    assign ctl.result  = result_q;

endmodule

// File: tb/tb_dot_prod_seq.sv
// Bench for dot_prod_seq: behavioural RAM and MAC around the DUT, directed
// runs with hand-computed results, and a negedge monitor that scores reads,
// MAC clears and completions against queued expectations.
module tb_dot_prod_seq;
    import dot_prod_seq_pkg::*;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic                     ram_rd_en;
    logic [ADDR_W-1:0]        ram_addr;
    logic signed [DATA_W-1:0] ram_a;
    logic signed [DATA_W-1:0] ram_b;
    logic signed [DATA_W-1:0] mac_in1;
    logic signed [DATA_W-1:0] mac_in2;
    logic                     mac_clr;
    logic signed [ACC_W-1:0]  mac_acc;

    logic signed [DATA_W-1:0] mem_a [16];
    logic signed [DATA_W-1:0] mem_b [16];

    exp_t rd_q[$];
    exp_t clr_q[$];
    exp_t res_q[$];
    exp_t mon_e;

    dot_prod_seq_if ctl();

    dot_prod_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctl         (ctl),
        .ram_rd_en_o (ram_rd_en),
        .ram_addr_o  (ram_addr),
        .ram_a_i     (ram_a),
        .ram_b_i     (ram_b),
        .mac_in1_o   (mac_in1),
        .mac_in2_o   (mac_in2),
        .mac_clr_o   (mac_clr),
        .mac_acc_i   (mac_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency operand RAM.
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_a <= mem_a[ram_addr];
            ram_b <= mem_b[ram_addr];
        end
    end

    // Signed MAC.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_acc <= '0;
        else if (mac_clr) mac_acc <= '0;
        else              mac_acc <= mac_acc + ACC_W'(mac_in1) * ACC_W'(mac_in2);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: score every read strobe, clear and done against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) begin
                if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                else begin
                    mon_e = rd_q.pop_front();
                    check("read_cycle", cyc, mon_e.cyc);
                    check("read_addr", int'(ram_addr), mon_e.val);
                end
            end
            if (mac_clr) begin
                if (clr_q.size() == 0) check("unexpected_clr", 1, 0);
                else begin
                    mon_e = clr_q.pop_front();
                    check("clr_cycle", cyc, mon_e.cyc);
                end
            end
            if (ctl.done) begin
                if (res_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    mon_e = res_q.pop_front();
                    check("done_cycle", cyc, mon_e.cyc);
                    check("result", int'(ctl.result), mon_e.val);
                    check("busy_at_done", int'(ctl.busy), 0);
                end
            end
        end
    end

    task automatic check_all_zero();
        check("rst_busy",   int'(ctl.busy), 0);
        check("rst_done",   int'(ctl.done), 0);
        check("rst_result", int'(ctl.result), 0);
        check("rst_rd_en",  int'(ram_rd_en), 0);
        check("rst_addr",   int'(ram_addr), 0);
        check("rst_clr",    int'(mac_clr), 0);
        check("rst_in1",    int'(mac_in1), 0);
        check("rst_in2",    int'(mac_in2), 0);
    endtask

    task automatic set_ab(input int i, input int a, input int b);
        mem_a[i] = DATA_W'(a);
        mem_b[i] = DATA_W'(b);
    endtask

    // Issue start in cycle 0 and queue the expected reads, clear and result.
    // poke > 0 re-asserts start in that relative cycle, which must be ignored.
    task automatic run(input int len_req, input int exp_res, input int poke);
        int le;
        int k;
        le = (len_req > 16) ? 16 : len_req;
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < le; i++) rd_q.push_back('{k + 1 + i, i});
        if (le > 0) clr_q.push_back('{k + 1, 0});
        res_q.push_back('{k + ((le == 0) ? 1 : le + 4), exp_res});
        ctl.start = 1'b1;
        ctl.len   = LEN_W'(len_req);
        for (int n = 0; n < le + 20; n++) begin
            @(negedge clk);
            ctl.start = ((cyc - k) == poke);
            ctl.len   = LEN_W'(1);
            if (le > 0 && ((cyc - k) == 1 || (cyc - k) == le + 3))
                check("busy_active", int'(ctl.busy), 1);
            #1;
            if (res_q.size() == 0) break;
        end
        if (res_q.size() != 0) begin
            check("done_timeout", 0, 1);
            rd_q.delete();
            clr_q.delete();
            res_q.delete();
        end
        @(posedge clk);
        #1;
        ctl.start = 1'b0;
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        ctl.start = 1'b0;
        ctl.len   = '0;
        for (int i = 0; i < 16; i++) set_ab(i, 0, 0);
        #12;
        check_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic vector: 5+12+21+32.
        set_ab(0, 1, 5); set_ab(1, 2, 6); set_ab(2, 3, 7); set_ab(3, 4, 8);
        run(4, 70, 0);

        // Full-length extremes.
        for (int i = 0; i < 16; i++) set_ab(i, -128, -128);
        run(16, 262144, 0);
        for (int i = 0; i < 16; i++) set_ab(i, -128, 127);
        run(16, -260096, 0);

        // Empty vector, then an over-long request clamped to 16: sum 0..15.
        run(0, 0, 0);
        for (int i = 0; i < 16; i++) set_ab(i, i, 1);
        run(20, 120, 0);

        // Back-to-back runs; the second starts the cycle after done.
        set_ab(0, 3, 10); set_ab(1, -4, 10);
        run(2, -10, 0);
        set_ab(0, 7, -2); set_ab(1, 7, 5);
        run(2, 21, 0);

        // Start pulses in mid-ISSUE and in the DONE cycle are ignored.
        set_ab(0, 1, 2); set_ab(1, 1, 3); set_ab(2, 1, 4); set_ab(3, 1, 5);
        run(4, 14, 2);
        set_ab(0, -9, 9);
        run(1, -81, 5);

        // Reset during DRAIN aborts the run with no done pulse.
        set_ab(0, -1, 4); set_ab(1, 2, -5); set_ab(2, -3, 6);
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 3; i++) rd_q.push_back('{k + 1 + i, i});
        clr_q.push_back('{k + 1, 0});
        ctl.start = 1'b1;
        ctl.len   = LEN_W'(3);
        @(negedge clk);
        ctl.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_done_after_abort", int'(ctl.result), 0);

        run(3, -32, 0);

        repeat (4) @(negedge clk);
        check("reads_left", rd_q.size(), 0);
        check("clrs_left", clr_q.size(), 0);
        check("results_left", res_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
